// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, IR field layout,
// FSM states and the opcode-to-instruction-class mapping.
package cpu_ctrl_pkg;

    localparam int OPC_LSB     = 27;
    localparam int RA_LSB      = 23;
    localparam int RB_LSB      = 19;
    localparam int RC_LSB      = 15;
    localparam int REG_FIELD_W = 4;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALTED
    } state_e;

    typedef enum logic [3:0] {
        CLS_LD, CLS_ST, CLS_ALU3, CLS_UNARY, CLS_MULDIV,
        CLS_MFHI, CLS_MFLO, CLS_NOP, CLS_HALT, CLS_ILL
    } iclass_e;

    function automatic iclass_e op_class(input logic [4:0] op);
        case (op)
            OP_LD:                           return CLS_LD;
            OP_ST:                           return CLS_ST;
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_ROR, OP_ROL, OP_SHR, OP_SHRA,
            OP_SHL:                          return CLS_ALU3;
            OP_NEG, OP_NOT:                  return CLS_UNARY;
            OP_MUL, OP_DIV:                  return CLS_MULDIV;
            OP_MFHI:                         return CLS_MFHI;
            OP_MFLO:                         return CLS_MFLO;
            OP_NOP:                          return CLS_NOP;
            OP_HALT:                         return CLS_HALT;
            default:                         return CLS_ILL;
        endcase
    endfunction

endpackage

// File: rtl/reg_select_decode.sv
// Converts the enabled IR register fields into a combined one-hot GPR strobe.
module reg_select_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int NUM_GPR = 16
) (
    input  logic [REG_FIELD_W-1:0] ra_i,
    input  logic [REG_FIELD_W-1:0] rb_i,
    input  logic [REG_FIELD_W-1:0] rc_i,
    input  logic                   en_ra_i,
    input  logic                   en_rb_i,
    input  logic                   en_rc_i,
    output logic [NUM_GPR-1:0]     sel_o
);

    always_comb begin
        sel_o = '0;
        for (int unsigned i = 0; i < NUM_GPR; i++) begin
            sel_o[i] = (en_ra_i && (32'(ra_i) == i)) ||
                       (en_rb_i && (32'(rb_i) == i)) ||
                       (en_rc_i && (32'(rc_i) == i));
        end
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control FSM sequencing fetch/decode/execute on the single-bus datapath.
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_GPR = 16,
    parameter int OP_W    = 5
) (
    input  logic               Clock,
    input  logic               clr,
    input  logic               Strt,
    input  logic               Stop,
    input  logic [DATA_W-1:0]  IR,
    output logic [NUM_GPR-1:0] Rin,
    output logic [NUM_GPR-1:0] Rout,
    output logic               HIin,
    output logic               LOin,
    output logic               HIout,
    output logic               LOout,
    output logic               ZHIout,
    output logic               ZLOout,
    output logic               Zin,
    output logic               Yin,
    output logic               PCin,
    output logic               PCout,
    output logic               IncPC,
    output logic               MARin,
    output logic               MDRin,
    output logic               MDRout,
    output logic               IRin,
    output logic               Read,
    output logic               Write,
    output logic [OP_W-1:0]    alu_op,
    output logic               Run,
    output logic               illegal_op
);

    state_e  state_q, state_d;
    iclass_e cls;
    logic    boundary;
    logic    rin_ra, rout_ra, rout_rb, rout_rc;
    logic    ir_unused;

    assign alu_op    = IR[OPC_LSB +: OP_W];
    assign cls       = op_class(IR[OPC_LSB +: 5]);
    assign ir_unused = ^IR[RC_LSB-1:0];
    assign Run       = (state_q != S_IDLE) && (state_q != S_HALTED);

    always_ff @(posedge Clock) begin
        if (clr) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOP/HALT resolve in T2 from the IR presented that cycle; others decode from T3.
    always_comb begin
        state_d  = state_q;
        boundary = 1'b0;
        case (state_q)
            S_IDLE:   if (Strt && !Stop) state_d = S_T0;
            S_T0:     state_d = S_T1;
            S_T1:     state_d = S_T2;
            S_T2: begin
                if (cls == CLS_HALT)     state_d = S_HALTED;
                else if (cls == CLS_NOP) boundary = 1'b1;
                else                     state_d = S_T3;
            end
            S_T3: begin
                if (cls == CLS_MFHI || cls == CLS_MFLO || cls == CLS_ILL) boundary = 1'b1;
                else                                                      state_d  = S_T4;
            end
            S_T4: begin
                if (cls == CLS_UNARY) boundary = 1'b1;
                else                  state_d  = S_T5;
            end
            S_T5: begin
                if (cls == CLS_MULDIV) state_d  = S_T6;
                else                   boundary = 1'b1;
            end
            S_T6:     boundary = 1'b1;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
        if (boundary) state_d = Stop ? S_IDLE : S_T0;
    end

    always_comb begin
        rin_ra = 1'b0; rout_ra = 1'b0; rout_rb = 1'b0; rout_rc = 1'b0;
        HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0;
        ZHIout = 1'b0; ZLOout = 1'b0; Zin = 1'b0; Yin = 1'b0;
        PCin = 1'b0; PCout = 1'b0; IncPC = 1'b0; MARin = 1'b0;
        MDRin = 1'b0; MDRout = 1'b0; IRin = 1'b0; Read = 1'b0; Write = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
            S_T1: begin ZLOout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin
                case (cls)
                    CLS_ALU3:      begin rout_rb = 1'b1; Yin = 1'b1; end
                    CLS_UNARY:     begin rout_rb = 1'b1; Zin = 1'b1; end
                    CLS_MULDIV:    begin rout_ra = 1'b1; Yin = 1'b1; end
                    CLS_MFHI:      begin HIout = 1'b1; rin_ra = 1'b1; end
                    CLS_MFLO:      begin LOout = 1'b1; rin_ra = 1'b1; end
                    CLS_LD, CLS_ST: begin rout_rb = 1'b1; MARin = 1'b1; end
                    CLS_ILL:       illegal_op = 1'b1;
                    default:       ;
                endcase
            end
            S_T4: begin
                case (cls)
                    CLS_ALU3:   begin rout_rc = 1'b1; Zin = 1'b1; end
                    CLS_UNARY:  begin ZLOout = 1'b1; rin_ra = 1'b1; end
                    CLS_MULDIV: begin rout_rb = 1'b1; Zin = 1'b1; end
                    CLS_LD:     begin Read = 1'b1; MDRin = 1'b1; end
                    CLS_ST:     begin rout_ra = 1'b1; MDRin = 1'b1; end
                    default:    ;
                endcase
            end
            S_T5: begin
                case (cls)
                    CLS_ALU3:   begin ZLOout = 1'b1; rin_ra = 1'b1; end
                    CLS_MULDIV: begin ZLOout = 1'b1; LOin = 1'b1; end
                    CLS_LD:     begin MDRout = 1'b1; rin_ra = 1'b1; end
                    CLS_ST:     Write = 1'b1;
                    default:    ;
                endcase
            end
            S_T6:    begin ZHIout = 1'b1; HIin = 1'b1; end
            default: ;
        endcase
    end

    reg_select_decode #(.NUM_GPR(NUM_GPR)) u_rin_dec (
        .ra_i    (IR[RA_LSB +: REG_FIELD_W]),
        .rb_i    (IR[RB_LSB +: REG_FIELD_W]),
        .rc_i    (IR[RC_LSB +: REG_FIELD_W]),
        .en_ra_i (rin_ra),
        .en_rb_i (1'b0),
        .en_rc_i (1'b0),
        .sel_o   (Rin)
    );

    reg_select_decode #(.NUM_GPR(NUM_GPR)) u_rout_dec (
        .ra_i    (IR[RA_LSB +: REG_FIELD_W]),
        .rb_i    (IR[RB_LSB +: REG_FIELD_W]),
        .rc_i    (IR[RC_LSB +: REG_FIELD_W]),
        .en_ra_i (rout_ra),
        .en_rb_i (rout_rb),
        .en_rc_i (rout_rc),
        .sel_o   (Rout)
    );

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed table, corner sequences, and random instructions
// checked cycle by cycle against a per-instruction strobe-list model.
module tb_control_unit;

    logic        Clock = 1'b0;
    logic        clr, Strt, Stop;
    logic [31:0] IR;
    logic [15:0] Rin, Rout;
    logic HIin, LOin, HIout, LOout, ZHIout, ZLOout, Zin, Yin;
    logic PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Read, Write, Run, illegal_op;
    logic [4:0]  alu_op;

    always #5 Clock = ~Clock;

    control_unit #(.DATA_W(32), .NUM_GPR(16), .OP_W(5)) dut (
        .Clock(Clock), .clr(clr), .Strt(Strt), .Stop(Stop), .IR(IR),
        .Rin(Rin), .Rout(Rout), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .ZHIout(ZHIout), .ZLOout(ZLOout), .Zin(Zin), .Yin(Yin), .PCin(PCin), .PCout(PCout),
        .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Read(Read), .Write(Write), .alu_op(alu_op), .Run(Run), .illegal_op(illegal_op)
    );

    typedef struct packed {
        logic [15:0] rin, rout;
        logic hiin, loin, hiout, loout, zhiout, zloout, zin, yin;
        logic pcin, pcout, incpc, marin, mdrin, mdrout, irin, rd, wr, run, ill;
    } ctl_t;

    ctl_t act;
    assign act = {Rin, Rout, HIin, LOin, HIout, LOout, ZHIout, ZLOout, Zin, Yin,
                  PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Read, Write, Run, illegal_op};

    int   n_cmp = 0;
    int   n_err = 0;
    ctl_t exp_q[$];
    logic exp_halt;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string nm, input ctl_t exp);
        n_cmp++;
        if (act !== exp || alu_op !== IR[31:27]) begin
            n_err++;
            $display("FAIL %s: got %h alu_op %b, want %h alu_op %b", nm, act, alu_op, exp, IR[31:27]);
        end
    endtask

    function automatic ctl_t base();
        ctl_t s = '0;
        s.run = 1'b1;
        return s;
    endfunction

    function automatic ctl_t t0_pat();
        ctl_t s = base();
        s.pcout = 1'b1; s.marin = 1'b1; s.incpc = 1'b1; s.zin = 1'b1;
        return s;
    endfunction

    // Reference: list of per-cycle strobe sets for one instruction, T0 first.
    task automatic build(input logic [31:0] ir);
        ctl_t s;
        logic [4:0]  op;
        logic [15:0] ra, rb, rc;
        op = ir[31:27];
        ra = 16'h1 << ir[26:23];
        rb = 16'h1 << ir[22:19];
        rc = 16'h1 << ir[18:15];
        exp_q.delete();
        exp_halt = 1'b0;
        exp_q.push_back(t0_pat());
        s = base(); s.zloout = 1; s.pcin = 1; s.rd = 1; s.mdrin = 1; exp_q.push_back(s);
        s = base(); s.mdrout = 1; s.irin = 1; exp_q.push_back(s);
        if (op inside {[5'd3:5'd11]}) begin
            s = base(); s.rout = rb; s.yin = 1;   exp_q.push_back(s);
            s = base(); s.rout = rc; s.zin = 1;   exp_q.push_back(s);
            s = base(); s.zloout = 1; s.rin = ra; exp_q.push_back(s);
        end else if (op == 5'd17 || op == 5'd18) begin
            s = base(); s.rout = rb; s.zin = 1;   exp_q.push_back(s);
            s = base(); s.zloout = 1; s.rin = ra; exp_q.push_back(s);
        end else if (op == 5'd15 || op == 5'd16) begin
            s = base(); s.rout = ra; s.yin = 1;    exp_q.push_back(s);
            s = base(); s.rout = rb; s.zin = 1;    exp_q.push_back(s);
            s = base(); s.zloout = 1; s.loin = 1;  exp_q.push_back(s);
            s = base(); s.zhiout = 1; s.hiin = 1;  exp_q.push_back(s);
        end else if (op == 5'd24) begin
            s = base(); s.hiout = 1; s.rin = ra; exp_q.push_back(s);
        end else if (op == 5'd25) begin
            s = base(); s.loout = 1; s.rin = ra; exp_q.push_back(s);
        end else if (op == 5'd0) begin
            s = base(); s.rout = rb; s.marin = 1;   exp_q.push_back(s);
            s = base(); s.rd = 1; s.mdrin = 1;      exp_q.push_back(s);
            s = base(); s.mdrout = 1; s.rin = ra;   exp_q.push_back(s);
        end else if (op == 5'd2) begin
            s = base(); s.rout = rb; s.marin = 1; exp_q.push_back(s);
            s = base(); s.rout = ra; s.mdrin = 1; exp_q.push_back(s);
            s = base(); s.wr = 1;                 exp_q.push_back(s);
        end else if (op == 5'd27) begin
            exp_halt = 1'b1;
        end else if (op != 5'd26) begin
            s = base(); s.ill = 1; exp_q.push_back(s);
        end
    endtask

    // Called with the DUT in T0; leaves it in T0, IDLE or HALTED.
    task automatic do_instr(input logic [31:0] ir, input logic stop);
        IR = ir;
        build(ir);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("op%b_step%0d", ir[31:27], i), exp_q[i]);
            Stop = (i == exp_q.size() - 1) ? stop : 1'($urandom_range(0, 1));
            tick();
        end
        Stop = 1'b0;
    endtask

    task automatic restart();
        Strt = 1'b1; Stop = 1'b0;
        tick();
        Strt = 1'b0;
    endtask

    task automatic settle(input logic stop);
        if (exp_halt) begin
            check("halted_quiet", '0);
            clr = 1'b1; tick(); clr = 1'b0;
            restart();
        end else if (stop) begin
            check("stopped_idle", '0);
            restart();
        end
    endtask

    typedef struct {
        logic [31:0] ir;
        int          len;
        int          step;
        logic [15:0] rin;
        logic [15:0] rout;
        logic        ill;
    } vec_t;

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{32'h1A920000, 6, 3, 16'h0000, 16'h0004, 1'b0};
        vecs[1]  = '{32'h1A920000, 6, 4, 16'h0000, 16'h0010, 1'b0};
        vecs[2]  = '{32'h1A920000, 6, 5, 16'h0020, 16'h0000, 1'b0};
        vecs[3]  = '{32'h79880000, 7, 5, 16'h0000, 16'h0000, 1'b0};
        vecs[4]  = '{32'h79880000, 7, 6, 16'h0000, 16'h0000, 1'b0};
        vecs[5]  = '{32'h00B80000, 6, 5, 16'h0002, 16'h0000, 1'b0};
        vecs[6]  = '{32'h13100000, 6, 4, 16'h0000, 16'h0040, 1'b0};
        vecs[7]  = '{32'hF8000000, 4, 3, 16'h0000, 16'h0000, 1'b1};
        vecs[8]  = '{32'h8C980000, 5, 4, 16'h0200, 16'h0000, 1'b0};
        vecs[9]  = '{32'hC7800000, 4, 3, 16'h8000, 16'h0000, 1'b0};
        vecs[10] = '{32'hD0000000, 3, 2, 16'h0000, 16'h0000, 1'b0};

        clr = 1'b1; Strt = 1'b0; Stop = 1'b0; IR = '0;
        tick(); tick();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("reset_idle", '0);
            tick();
        end
        Strt = 1'b1; tick(); Strt = 1'b0;
        check("strt_T0", t0_pat());

        // Directed table: spot strobes at a given step, then T0 exactly len cycles later.
        foreach (vecs[k]) begin
            IR = vecs[k].ir;
            for (int c = 0; c < vecs[k].len; c++) begin
                if (c == vecs[k].step) begin
                    n_cmp++;
                    if ({Rin, Rout, illegal_op} !== {vecs[k].rin, vecs[k].rout, vecs[k].ill}) begin
                        n_err++;
                        $display("FAIL vec%0d_step%0d: Rin=%h Rout=%h ill=%b, want Rin=%h Rout=%h ill=%b",
                                 k, c, Rin, Rout, illegal_op, vecs[k].rin, vecs[k].rout, vecs[k].ill);
                    end
                end
                tick();
            end
            check($sformatf("vec%0d_len", k), t0_pat());
        end

        foreach (vecs[k]) do_instr(vecs[k].ir, 1'b0);

        // Stop at ALU3 T5 ends in IDLE; Stop with Strt holds IDLE.
        do_instr(32'h1A920000, 1'b1);
        check("stop_idle0", '0);
        Stop = 1'b1; Strt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stop_strt_idle", '0);
        end
        Stop = 1'b0;
        tick();
        Strt = 1'b0;
        check("stop_release_T0", t0_pat());

        // clr during T4 of ADD abandons the instruction.
        IR = 32'h1A920000;
        for (int i = 0; i < 4; i++) tick();
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_mid_T4", '0);
        tick();
        check("clr_mid_idle", '0);
        restart();

        // HALT ignores Strt until clr.
        do_instr(32'hD8000000, 1'b0);
        Strt = 1'b1;
        for (int i = 0; i < 20; i++) begin
            check("halt_hold", '0);
            tick();
        end
        Strt = 1'b0;
        clr = 1'b1; tick(); clr = 1'b0;
        check("halt_clr_idle", '0);
        restart();

        for (int n = 0; n < 300; n++) begin
            logic [31:0] rir;
            logic        rstop;
            rir   = $urandom;
            rstop = ($urandom_range(0, 9) == 0);
            do_instr(rir, rstop);
            settle(rstop);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
